// File: rtl/dac_spi_tx.sv
// dac_spi_tx: frames one 12-bit sample per handshake as a 16-bit {CMD,data} SPI write, MSB first.
// Optional DAC_SIGNED_IN_EN: sample_in is two's complement and is sent as offset binary.
module dac_spi_tx #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 2,
  parameter logic [3:0]  CMD     = 4'b0011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        DAC_CS_N,
  output logic        DAC_SCLK,
  output logic        DAC_DIN,
  output logic        busy,
  output logic        frame_done
);
  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t        state_q;
  logic [PW-1:0] phase_q;
  logic [GW-1:0] gap_q;
  logic [4:0]    bits_q;
  logic [14:0]   shreg_q;
  logic          cs_n_q, sclk_q, din_q, busy_q, done_q;
  logic [11:0]   data_d;
  logic [15:0]   frame_d;

  always_comb begin
`ifdef DAC_SIGNED_IN_EN
    data_d = {~sample_in[11], sample_in[10:0]};
`else
    data_d = sample_in;
`endif
    frame_d = {CMD, data_d};
  end

  assign sample_ready = (state_q == IDLE);
  assign DAC_CS_N     = cs_n_q;
  assign DAC_SCLK     = sclk_q;
  assign DAC_DIN      = din_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= '0;
      gap_q   <= '0;
      bits_q  <= '0;
      shreg_q <= '0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      din_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (sample_valid) begin
            state_q <= SETUP;
            shreg_q <= frame_d[14:0];
            din_q   <= frame_d[15];
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            phase_q <= '0;
            bits_q  <= 5'd16;
          end
        end
        SETUP: begin
          if (phase_q == PH_LAST) begin
            phase_q <= '0;
            sclk_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        SHIFT: begin
          if (phase_q != PH_LAST) begin
            phase_q <= phase_q + 1'b1;
          end else begin
            phase_q <= '0;
            if (sclk_q) begin
              // falling edge: advance DIN, except after bit 0 which is held through CS hold
              sclk_q <= 1'b0;
              bits_q <= bits_q - 1'b1;
              if (bits_q != 5'd1) begin
                din_q   <= shreg_q[14];
                shreg_q <= {shreg_q[13:0], 1'b0};
              end
            end else if (bits_q == 5'd0) begin
              state_q <= GAP;
              cs_n_q  <= 1'b1;
              din_q   <= 1'b0;
              done_q  <= 1'b1;
              gap_q   <= '0;
            end else begin
              sclk_q <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: default instance plus a CLK_DIV=1/CS_GAP=1/CMD=4'hF instance,
// a pin-level frame monitor and a sample-to-word reference model.
module tb_dac_spi_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cmp = 0;
  int mism = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst[2], val[2], rdy[2], cs[2], sck[2], sd[2], bsy[2], fd[2];
  logic [11:0] sin[2];

  dac_spi_tx dut0 (
    .clock(clk), .reset(rst[0]), .sample_in(sin[0]), .sample_valid(val[0]),
    .sample_ready(rdy[0]), .DAC_CS_N(cs[0]), .DAC_SCLK(sck[0]), .DAC_DIN(sd[0]),
    .busy(bsy[0]), .frame_done(fd[0]));

  dac_spi_tx #(.CLK_DIV(1), .CS_GAP(1), .CMD(4'b1111)) dut1 (
    .clock(clk), .reset(rst[1]), .sample_in(sin[1]), .sample_valid(val[1]),
    .sample_ready(rdy[1]), .DAC_CS_N(cs[1]), .DAC_SCLK(sck[1]), .DAC_DIN(sd[1]),
    .busy(bsy[1]), .frame_done(fd[1]));

  function automatic int div_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int gap_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [15:0] exp_word(input int i, input logic [11:0] s);
    logic [11:0] d;
`ifdef DAC_SIGNED_IN_EN
    d = 12'((int'(s) + 2048) % 4096);
`else
    d = s;
`endif
    return {((i == 0) ? 4'b0011 : 4'b1111), d};
  endfunction

  // Pin-level monitor: one record per completed CS_N-low window, one timestamp per accept.
  bit          in_fr[2], psck[2];
  int          len_c[2], rise_c[2], lat_c[2];
  logic [15:0] w_c[2];
  int unsigned last_acc[2];
  logic [15:0] w_log[2][32];
  int          len_log[2][32], rise_log[2][32], lat_log[2][32];
  bit          fd_log[2][32];
  int          nfr[2];
  int unsigned acc_t[2][32];
  int          nacc[2];
  int          sck_idle_err[2], fd_spur[2], busy_err[2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i] !== 1'b0) begin
        in_fr[i] = 1'b0;
      end else begin
        if (bsy[i] === rdy[i]) busy_err[i]++;
        if (val[i] === 1'b1 && rdy[i] === 1'b1) begin
          if (nacc[i] < 32) acc_t[i][nacc[i]] = cyc;
          nacc[i]++;
          last_acc[i] = cyc;
        end
        if (cs[i] === 1'b0) begin
          if (!in_fr[i]) begin
            in_fr[i] = 1'b1; len_c[i] = 0; rise_c[i] = 0; w_c[i] = '0;
            lat_c[i] = int'(cyc - last_acc[i]);
          end
          len_c[i]++;
          if (sck[i] === 1'b1 && !psck[i]) begin
            rise_c[i]++;
            w_c[i] = {w_c[i][14:0], sd[i]};
          end
        end else begin
          if (sck[i] !== 1'b0) sck_idle_err[i]++;
          if (in_fr[i]) begin
            if (nfr[i] < 32) begin
              w_log[i][nfr[i]] = w_c[i]; len_log[i][nfr[i]] = len_c[i];
              rise_log[i][nfr[i]] = rise_c[i]; lat_log[i][nfr[i]] = lat_c[i];
              fd_log[i][nfr[i]] = (fd[i] === 1'b1);
            end
            nfr[i]++;
            in_fr[i] = 1'b0;
          end else if (fd[i] !== 1'b0) begin
            fd_spur[i]++;
          end
        end
      end
      psck[i] = (sck[i] === 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [11:0] s, input bit hold);
    int n0;
    bit ok;
    n0 = nacc[i];
    ok = 1'b0;
    sin[i] = s;
    val[i] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      if (nacc[i] != n0) begin ok = 1'b1; break; end
    end
    #1;
    if (!hold) val[i] = 1'b0;
    cmp++;
    if (!ok) begin mism++; $display("FAIL accept_timeout dut%0d: accepted=0 required=1", i); end
  endtask

  task automatic wait_frames(input int i, input int n);
    int c;
    for (c = 0; c < 600 && nfr[i] < n; c++) tick();
    cmp++;
    if (nfr[i] < n) begin mism++; $display("FAIL frame_timeout dut%0d: frames=%0d required=%0d", i, nfr[i], n); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; val[i] = 1'b1; sin[i] = 12'($urandom);
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      cmp++; if (cs[i] !== 1'b1) begin mism++; $display("FAIL reset_cs dut%0d: got %b required 1", i, cs[i]); end
      cmp++; if (sck[i] !== 1'b0) begin mism++; $display("FAIL reset_sclk dut%0d: got %b required 0", i, sck[i]); end
      cmp++; if (sd[i] !== 1'b0) begin mism++; $display("FAIL reset_din dut%0d: got %b required 0", i, sd[i]); end
      cmp++; if (bsy[i] !== 1'b0) begin mism++; $display("FAIL reset_busy dut%0d: got %b required 0", i, bsy[i]); end
      cmp++; if (fd[i] !== 1'b0) begin mism++; $display("FAIL reset_done dut%0d: got %b required 0", i, fd[i]); end
      val[i] = 1'b0; rst[i] = 1'b0;
      cmp++; if (rdy[i] !== 1'b1) begin mism++; $display("FAIL reset_ready dut%0d: got %b required 1", i, rdy[i]); end
    end
  endtask

  task automatic test_single_and_random();
    logic [11:0] s[$];
    int f0, a0;
    f0 = nfr[0];
    s.push_back(12'hA5C);
    repeat (5) s.push_back(12'($urandom));
    foreach (s[k]) begin
      a0 = nacc[0];
      send(0, s[k], 1'b0);
      repeat (40) begin tick(); val[0] = 1'($urandom); sin[0] = 12'($urandom); end
      val[0] = 1'b0;
      wait_frames(0, f0 + k + 1);
      cmp++;
      if (nacc[0] != a0 + 1) begin mism++; $display("FAIL busy_valid_ignored: accepts=%0d required=%0d", nacc[0] - a0, 1); end
      repeat ($urandom_range(0, 3)) tick();
    end
    foreach (s[k]) begin
      cmp++;
      if (w_log[0][f0+k] !== exp_word(0, s[k])) begin
        mism++; $display("FAIL frame_word[%0d]: got %h required %h", k, w_log[0][f0+k], exp_word(0, s[k]));
      end
      cmp++;
      if (len_log[0][f0+k] != 33 * div_of(0) || rise_log[0][f0+k] != 16 || lat_log[0][f0+k] != 1 || !fd_log[0][f0+k]) begin
        mism++; $display("FAIL frame_shape[%0d]: cs_low=%0d rises=%0d latency=%0d done=%0d required %0d/16/1/1",
                         k, len_log[0][f0+k], rise_log[0][f0+k], lat_log[0][f0+k], fd_log[0][f0+k], 33 * div_of(0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int f0, n0, per;
    f0 = nfr[0]; n0 = nacc[0];
    send(0, 12'h001, 1'b1);
    repeat (30) begin tick(); sin[0] = 12'($urandom); end
    send(0, 12'hFFE, 1'b0);
    wait_frames(0, f0 + 2);
    per = int'(acc_t[0][n0+1] - acc_t[0][n0]);
    cmp++;
    if (per != 1 + 33 * div_of(0) + gap_of(0)) begin
      mism++; $display("FAIL b2b_period: got %0d required %0d", per, 1 + 33 * div_of(0) + gap_of(0));
    end
    cmp++;
    if (w_log[0][f0] !== exp_word(0, 12'h001)) begin mism++; $display("FAIL b2b_word0: got %h required %h", w_log[0][f0], exp_word(0, 12'h001)); end
    cmp++;
    if (w_log[0][f0+1] !== exp_word(0, 12'hFFE)) begin mism++; $display("FAIL b2b_word1: got %h required %h", w_log[0][f0+1], exp_word(0, 12'hFFE)); end
  endtask

  task automatic test_reset_midframe();
    int f0, r;
    logic prev;
    f0 = nfr[0]; r = 0;
    send(0, 12'($urandom), 1'b0);
    for (int c = 0; c < 400 && r < 5; c++) begin
      prev = sck[0];
      tick();
      if (sck[0] === 1'b1 && prev === 1'b0) r++;
    end
    cmp++;
    if (r != 5) begin mism++; $display("FAIL midframe_rises: got %0d required 5", r); end
    rst[0] = 1'b1; val[0] = 1'b1;
    tick();
    cmp++;
    if ({cs[0], sck[0], sd[0], bsy[0], fd[0]} !== 5'b10000) begin
      mism++; $display("FAIL midframe_reset_pins: cs/sclk/din/busy/done=%b required 10000", {cs[0], sck[0], sd[0], bsy[0], fd[0]});
    end
    val[0] = 1'b0; rst[0] = 1'b0;
    cmp++;
    if (rdy[0] !== 1'b1) begin mism++; $display("FAIL midframe_ready: got %b required 1", rdy[0]); end
    send(0, 12'h123, 1'b0);
    wait_frames(0, f0 + 1);
    cmp++;
    if (w_log[0][f0] !== exp_word(0, 12'h123) || rise_log[0][f0] != 16) begin
      mism++; $display("FAIL post_reset_frame: got %h rises=%0d required %h rises=16", w_log[0][f0], rise_log[0][f0], exp_word(0, 12'h123));
    end
  endtask

  task automatic test_fast_config();
    logic [11:0] s[4];
    int f0, n0, per;
    f0 = nfr[1]; n0 = nacc[1];
    foreach (s[k]) s[k] = 12'($urandom);
    foreach (s[k]) send(1, s[k], k < 3);
    wait_frames(1, f0 + 4);
    foreach (s[k]) begin
      cmp++;
      if (w_log[1][f0+k] !== exp_word(1, s[k]) || len_log[1][f0+k] != 33 || rise_log[1][f0+k] != 16 || !fd_log[1][f0+k]) begin
        mism++; $display("FAIL fast_frame[%0d]: word=%h cs_low=%0d rises=%0d done=%0d required %h/33/16/1",
                         k, w_log[1][f0+k], len_log[1][f0+k], rise_log[1][f0+k], fd_log[1][f0+k], exp_word(1, s[k]));
      end
      if (k > 0) begin
        per = int'(acc_t[1][n0+k] - acc_t[1][n0+k-1]);
        cmp++;
        if (per != 1 + 33 * div_of(1) + gap_of(1)) begin mism++; $display("FAIL fast_period[%0d]: got %0d required 35", k, per); end
      end
    end
  endtask

  task automatic test_encoding();
    int f0;
    logic [15:0] e0, e1;
`ifdef DAC_SIGNED_IN_EN
    e0 = 16'h3000; e1 = 16'h3FFF;
`else
    e0 = 16'h3800; e1 = 16'h37FF;
`endif
    f0 = nfr[0];
    send(0, 12'h800, 1'b0);
    send(0, 12'h7FF, 1'b0);
    wait_frames(0, f0 + 2);
    cmp++; if (w_log[0][f0] !== e0) begin mism++; $display("FAIL enc_800: got %h required %h", w_log[0][f0], e0); end
    cmp++; if (w_log[0][f0+1] !== e1) begin mism++; $display("FAIL enc_7ff: got %h required %h", w_log[0][f0+1], e1); end
  endtask

  task automatic test_pin_invariants();
    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      cmp++; if (sck_idle_err[i] != 0) begin mism++; $display("FAIL sclk_while_cs_high dut%0d: got %0d required 0", i, sck_idle_err[i]); end
      cmp++; if (fd_spur[i] != 0) begin mism++; $display("FAIL stray_frame_done dut%0d: got %0d required 0", i, fd_spur[i]); end
      cmp++; if (busy_err[i] != 0) begin mism++; $display("FAIL busy_vs_ready dut%0d: got %0d required 0", i, busy_err[i]); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_and_random();
    test_back_to_back();
    test_reset_midframe();
    test_fast_config();
    test_encoding();
    test_pin_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
    $finish;
  end
endmodule
